// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble converter, two's-complement in, sign + 4 BCD digits out
module bin_to_bcd_seq #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_Start,
  input  logic [W-1:0] in_Bin,
  output logic         out_Busy,
  output logic         out_Done,
  output logic         out_Signo,
  output logic [3:0]   out_Thousands,
  output logic [3:0]   out_Hundreds,
  output logic [3:0]   out_Tens,
  output logic [3:0]   out_Units
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic sign_q, sign_d, signo_q, signo_d;
  logic [W-1:0] mag_q, mag_d;
  logic [15:0] bcd_q, bcd_d, dig_q, dig_d, adj;
  logic [3:0] cnt_q, cnt_d;
  logic [15+W:0] sh;
  genvar g;
  for (g = 0; g < 4; g++) begin : g_adj
    assign adj[4*g +: 4] = bcd_q[4*g +: 4] >= 4'd5 ? bcd_q[4*g +: 4] + 4'd3 : bcd_q[4*g +: 4];
  end
  assign sh = {adj, mag_q} << 1;
  // Next state: capture on start, one add-3/shift step per SHIFT cycle, publish on entry to DONE
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    signo_d = signo_q;
    case (state_q)
      IDLE: if (in_Start) begin
        state_d = SHIFT;
        sign_d  = in_Bin[W-1];
        mag_d   = in_Bin[W-1] ? -in_Bin : in_Bin;
        bcd_d   = '0;
        cnt_d   = 4'(W);
      end
      SHIFT: begin
        bcd_d = sh[15+W:W];
        mag_d = sh[W-1:0];
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = DONE;
          dig_d   = sh[15+W:W];
          signo_d = sign_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // State registers with synchronous reset clearing all results
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      dig_q   <= '0;
      signo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      signo_q <= signo_d;
    end
  end
  assign out_Busy      = state_q != IDLE;
  assign out_Done      = state_q == DONE;
  assign out_Signo     = signo_q;
  assign out_Thousands = dig_q[15:12];
  assign out_Hundreds  = dig_q[11:8];
  assign out_Tens      = dig_q[7:4];
  assign out_Units     = dig_q[3:0];
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: scoreboard bench for W=12 and W=4 converters against an arithmetic model
module tb_bin_to_bcd_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst12, start12, busy12, done12, sg12;
  logic [11:0] bin12;
  logic [3:0] th12, hu12, te12, un12;
  logic rst4, start4, busy4, done4, sg4;
  logic [3:0] bin4;
  logic [3:0] th4, hu4, te4, un4;
  int total = 0, bad = 0, cyc = 0;
  logic [16:0] q12[$], q4[$];
  logic [16:0] lastr;

  bin_to_bcd_seq #(.W(12)) dut12 (.clk(clk), .rst(rst12), .in_Start(start12), .in_Bin(bin12),
    .out_Busy(busy12), .out_Done(done12), .out_Signo(sg12), .out_Thousands(th12),
    .out_Hundreds(hu12), .out_Tens(te12), .out_Units(un12));
  bin_to_bcd_seq #(.W(4)) dut4 (.clk(clk), .rst(rst4), .in_Start(start4), .in_Bin(bin4),
    .out_Busy(busy4), .out_Done(done4), .out_Signo(sg4), .out_Thousands(th4),
    .out_Hundreds(hu4), .out_Tens(te4), .out_Units(un4));

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [16:0] model(input int v);
    int m;
    m = v < 0 ? -v : v;
    return {v < 0 ? 1'b1 : 1'b0, 4'(m / 1000 % 10), 4'(m / 100 % 10), 4'(m / 10 % 10), 4'(m % 10)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitors: pop expected result whenever a converter pulses done
  always @(negedge clk) if (done12) begin
    if (q12.size() == 0) begin
      total++; bad++;
      $display("FAIL unexpected_done12: got %0h expected none", {sg12, th12, hu12, te12, un12});
    end else chk("result12", {sg12, th12, hu12, te12, un12}, q12.pop_front());
  end
  always @(negedge clk) if (done4) begin
    if (q4.size() == 0) begin
      total++; bad++;
      $display("FAIL unexpected_done4: got %0h expected none", {sg4, th4, hu4, te4, un4});
    end else chk("result4", {sg4, th4, hu4, te4, un4}, q4.pop_front());
  end

  // waits for done12 (called one negedge after acceptance), scrambling in_Bin meanwhile
  task automatic wait12(output int n, input logic [16:0] hold, input bit poke);
    n = 1;
    while (!done12 && n < 60) begin
      if (n == 5) begin
        chk("shift_busy", busy12, 1);
        chk("shift_hold", {sg12, th12, hu12, te12, un12}, hold);
      end
      if (poke && n == 4) start12 = 1'b1;
      if (poke && n == 5) start12 = 1'b0;
      @(negedge clk);
      n++;
      bin12 = poke ? 12'd5 : 12'($urandom);
    end
    if (!done12) begin
      total++; bad++;
      $display("FAIL timeout12: got no done expected done");
    end
  endtask

  task automatic pulse12(input int v, output int n, input bit poke);
    @(negedge clk);
    start12 = 1'b1;
    bin12 = 12'(v);
    q12.push_back(model(v));
    @(negedge clk);
    start12 = 1'b0;
    wait12(n, lastr, poke);
    lastr = model(v);
  endtask

  initial begin
    int n, tprev, off;
    int vals[4] = '{2047, -2048, 8, 0};
    rst12 = 1; start12 = 0; bin12 = 0;
    rst4 = 1; start4 = 0; bin4 = 0;
    lastr = '0;
    fork
      begin
        repeat (2) @(negedge clk);
        chk("rst_busy", busy12, 0);
        chk("rst_done", done12, 0);
        chk("rst_out", {sg12, th12, hu12, te12, un12}, 0);
        rst12 = 0;
        pulse12(-475, n, 0);
        chk("latency_m475", n, 13);
        @(negedge clk);
        chk("idle_after_done", busy12, 0);
        start12 = 1'b1;
        tprev = 0;
        for (int i = 0; i < 4; i++) begin
          bin12 = 12'(vals[i]);
          q12.push_back(model(vals[i]));
          @(negedge clk);
          wait12(n, lastr, 0);
          lastr = model(vals[i]);
          if (i > 0) chk("spacing", cyc - tprev, 14);
          tprev = cyc;
          @(negedge clk);
        end
        start12 = 1'b0;
        pulse12(-1097, n, 1);
        start12 = 1'b1;
        bin12 = 12'd5;
        @(negedge clk);
        start12 = 1'b0;
        chk("start_in_done_ignored", busy12, 0);
        repeat (20) @(negedge clk);
        chk("no_extra_done", q12.size(), 0);
        start12 = 1'b1;
        bin12 = 12'd1234;
        @(negedge clk);
        start12 = 1'b0;
        repeat (4) @(negedge clk);
        rst12 = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy12, 0);
        chk("abort_done", done12, 0);
        chk("abort_out", {sg12, th12, hu12, te12, un12}, 0);
        rst12 = 1'b0;
        start12 = 1'b1;
        bin12 = 12'd9;
        q12.push_back(model(9));
        lastr = '0;
        @(negedge clk);
        start12 = 1'b0;
        wait12(n, lastr, 0);
        lastr = model(9);
        chk("latency_after_rst", n, 13);
        @(negedge clk);
        rst12 = 1'b1;
        start12 = 1'b1;
        bin12 = 12'd77;
        @(negedge clk);
        chk("rst_start_busy", busy12, 0);
        chk("rst_start_out", {sg12, th12, hu12, te12, un12}, 0);
        rst12 = 1'b0;
        start12 = 1'b0;
        @(negedge clk);
        chk("rst_start_stay_idle", busy12, 0);
        lastr = '0;
        off = $urandom_range(0, 4095);
        start12 = 1'b1;
        for (int k = 0; k < 4096; k++) begin
          int v;
          v = ((k + off) % 4096) - 2048;
          bin12 = 12'(v);
          q12.push_back(model(v));
          @(negedge clk);
          wait12(n, lastr, 0);
          lastr = model(v);
          @(negedge clk);
        end
        start12 = 1'b0;
        repeat (3) @(negedge clk);
        chk("q12_drained", q12.size(), 0);
      end
      begin
        repeat (2) @(negedge clk);
        chk("rst4_out", {busy4, done4, sg4, th4, hu4, te4, un4}, 0);
        rst4 = 0;
        for (int r = 0; r < 4; r++) begin
          int o;
          o = $urandom_range(0, 15);
          for (int k = 0; k < 16; k++) begin
            int v, m;
            v = ((k + o) % 16) - 8;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            start4 = 1'b1;
            bin4 = 4'(v);
            q4.push_back(model(v));
            @(negedge clk);
            start4 = 1'b0;
            m = 1;
            while (!done4 && m < 30) begin
              @(negedge clk);
              m++;
              bin4 = 4'($urandom);
            end
            chk("latency4", m, 5);
            @(negedge clk);
          end
        end
        chk("q4_drained", q4.size(), 0);
      end
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
